// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, default latencies and FSM states.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_if.sv
// Pipeline-to-MDU connection: operation launch, mthi/mtlo writes, operands and results.
interface mdu_if;

    logic        Start;
    logic [1:0]  MDUOp;
    logic        HIWrite;
    logic        LOWrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDUOp, HIWrite, LOWrite, A, B,
                    input  Busy, HI, LO);
    modport slave  (input  Start, MDUOp, HIWrite, LOWrite, A, B,
                    output Busy, HI, LO);

endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: result computed at launch, held pending,
// and committed to HI/LO after a fixed number of Busy cycles.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic signed [63:0] a_s, b_s, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] res_hi, res_lo;

    always_comb begin
        a_s    = {{32{bus.A[31]}}, bus.A};
        b_s    = {{32{bus.B[31]}}, bus.B};
        prod_s = a_s * b_s;
        prod_u = {32'b0, bus.A} * {32'b0, bus.B};
        // A zero divisor re-commits the current HI/LO so the registers stay unchanged.
        res_hi = hi_q;
        res_lo = lo_q;
        unique case (mdu_op_e'(bus.MDUOp))
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_DIVU: begin
                if (bus.B != 32'd0) begin
                    res_lo = bus.A / bus.B;
                    res_hi = bus.A % bus.B;
                end
            end
            MDU_DIV: begin
                if (bus.B != 32'd0) begin
                    if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
                        res_lo = 32'h8000_0000;
                        res_hi = 32'h0000_0000;
                    end else begin
                        res_lo = $signed(bus.A) / $signed(bus.B);
                        res_hi = $signed(bus.A) % $signed(bus.B);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    phi_d   = res_hi;
                    plo_d   = res_lo;
                    cnt_d   = bus.MDUOp[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_d = RUN;
                end else begin
                    if (bus.HIWrite) hi_d = bus.A;
                    if (bus.LOWrite) lo_d = bus.A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.Busy = (state_q == RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized operations
// compared against an arithmetic reference model of HI/LO.
module tb_mdu;

    logic clk;
    logic reset;
    mdu_if bus();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    // Reference model: architectural effect of one operation on HI/LO.
    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sp, sq, sr;
        logic [63:0] up;
        case (op)
            2'b00: begin
                up = {32'b0, a} * {32'b0, b};
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi_m = sp[63:32];
                lo_m = sp[31:0];
            end
            2'b10: begin
                if (b != 0) begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            default: begin
                if (b != 0) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    lo_m = sq[31:0];
                    hi_m = sr[31:0];
                end
            end
        endcase
    endfunction

    // Called at a falling edge; launches an op and returns at the falling edge
    // of the first cycle after the last Busy cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mthi, input bit noisy, input string name);
        int n;
        int busy_bad;
        n = op[1] ? 10 : 5;
        bus.Start   = 1'b1;
        bus.MDUOp   = op;
        bus.A       = a;
        bus.B       = b;
        bus.HIWrite = with_mthi;
        bus.LOWrite = 1'b0;
        ref_op(op, a, b);
        @(negedge clk);
        busy_bad = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.Busy !== 1'b1) busy_bad++;
            bus.Start   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.HIWrite = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.LOWrite = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.MDUOp   = 2'($urandom_range(0, 3));
            bus.A       = $urandom;
            bus.B       = $urandom;
            @(negedge clk);
        end
        bus.Start   = 1'b0;
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        n_cmp++;
        if (busy_bad != 0) begin
            n_bad++;
            $display("FAIL %s busy_run: %0d of %0d Busy cycles low, required 0", name, busy_bad, n);
        end
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_end: Busy=%b required 0", name, bus.Busy);
        end
        n_cmp++;
        if (bus.HI !== hi_m) begin
            n_bad++;
            $display("FAIL %s hi: got %h required %h", name, bus.HI, hi_m);
        end
        n_cmp++;
        if (bus.LO !== lo_m) begin
            n_bad++;
            $display("FAIL %s lo: got %h required %h", name, bus.LO, lo_m);
        end
    endtask

    task automatic write_hilo(input bit wh, input bit wl, input logic [31:0] a);
        bus.HIWrite = wh;
        bus.LOWrite = wl;
        bus.A       = a;
        bus.MDUOp   = 2'($urandom_range(0, 3));
        if (wh) hi_m = a;
        if (wl) lo_m = a;
        @(negedge clk);
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mtx_busy: Busy=%b required 0", bus.Busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", bus.Busy); end
        n_cmp++;
        if (bus.HI !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h required 0", bus.HI); end
        n_cmp++;
        if (bus.LO !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h required 0", bus.LO); end
        hi_m = 32'd0;
        lo_m = 32'd0;
        // Start presented in the same cycle reset is released must be taken.
        reset = 1'b1;
        run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, "mult_neg2x3");
        n_cmp++;
        if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            n_bad++;
            $display("FAIL mult_const: got %h_%h required ffffffff_fffffffa", bus.HI, bus.LO);
        end
    endtask

    task automatic test_div();
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg7");
        n_cmp++;
        if ({bus.HI, bus.LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_bad++;
            $display("FAIL div_const: got %h_%h required ffffffff_fffffffd", bus.HI, bus.LO);
        end
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "divu_neg7");
        n_cmp++;
        if ({bus.HI, bus.LO} !== 64'h0000_0001_7FFF_FFFC) begin
            n_bad++;
            $display("FAIL divu_const: got %h_%h required 00000001_7ffffffc", bus.HI, bus.LO);
        end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_overflow");
        n_cmp++;
        if ({bus.HI, bus.LO} !== 64'h0000_0000_8000_0000) begin
            n_bad++;
            $display("FAIL div_ovf_const: got %h_%h required 00000000_80000000", bus.HI, bus.LO);
        end
    endtask

    task automatic test_mthi_mtlo();
        write_hilo(1'b1, 1'b0, 32'h1234_5678);
        write_hilo(1'b0, 1'b1, 32'h9ABC_DEF0);
        n_cmp++;
        if (bus.HI !== 32'h1234_5678 || bus.LO !== 32'h9ABC_DEF0) begin
            n_bad++;
            $display("FAIL mthi_mtlo: got %h/%h required 12345678/9abcdef0", bus.HI, bus.LO);
        end
        write_hilo(1'b1, 1'b1, 32'h0BAD_F00D);
        n_cmp++;
        if (bus.HI !== 32'h0BAD_F00D || bus.LO !== 32'h0BAD_F00D) begin
            n_bad++;
            $display("FAIL mt_both: got %h/%h required 0badf00d/0badf00d", bus.HI, bus.LO);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] lo_before;
        write_hilo(1'b1, 1'b0, 32'hAAAA_0000);
        lo_before = bus.LO;
        run_op(2'b10, 32'h1357_9BDF, 32'd0, 1'b0, 1'b0, "divu_by0");
        n_cmp++;
        if (bus.HI !== 32'hAAAA_0000 || bus.LO !== lo_before) begin
            n_bad++;
            $display("FAIL divu_by0_keep: got %h/%h required aaaa0000/%h", bus.HI, bus.LO, lo_before);
        end
        run_op(2'b11, 32'h8000_0001, 32'd0, 1'b0, 1'b1, "div_by0");
    endtask

    task automatic test_reset_mid_run();
        int late_bad;
        bus.Start = 1'b1;
        bus.MDUOp = 2'b00;
        bus.A     = 32'hFFFF_FFFF;
        bus.B     = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run: Busy=%b HI=%h LO=%h required 0/0/0", bus.Busy, bus.HI, bus.LO);
        end
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        late_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) late_bad++;
        end
        n_cmp++;
        if (late_bad != 0) begin
            n_bad++;
            $display("FAIL reset_no_commit: %0d cycles with Busy/HI/LO nonzero, required 0", late_bad);
        end
    endtask

    task automatic test_start_with_mthi();
        write_hilo(1'b1, 1'b0, 32'h1111_1111);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, "start_mthi");
        n_cmp++;
        if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFF1) begin
            n_bad++;
            $display("FAIL start_mthi_const: got %h/%h required ffffffff/fffffff1", bus.HI, bus.LO);
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1000, 1'b0, 1'b0, "b2b_multu");
        run_op(2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, "b2b_div");
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, "b2b_mult");
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 16));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0)
                write_hilo(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset       = 1'b0;
        bus.Start   = 1'b0;
        bus.MDUOp   = 2'b00;
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        bus.A       = 32'd0;
        bus.B       = 32'd0;
        hi_m        = 32'd0;
        lo_m        = 32'd0;
        @(negedge clk);
        test_reset();
        test_div();
        test_mthi_mtlo();
        test_div_zero();
        test_reset_mid_run();
        test_start_with_mthi();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
